// File: rtl/conv_window_buffer_strided_if.sv
// Pixel-in / window-out handshake bundle for conv_window_buffer_strided.
// slave is the block's view; master is the upstream/downstream side.
interface conv_window_buffer_strided_if #(
  parameter int N           = 3,
  parameter int BitSize     = 8,
  parameter int NumChannels = 1
);
  logic                               in_valid;
  logic                               in_ready;
  logic [NumChannels*BitSize-1:0]     in_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [NumChannels*N*N*BitSize-1:0] out_data;
  logic                               out_last;
  logic                               out_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_done
  );
endinterface

// File: rtl/conv_window_buffer_strided.sv
// Streaming NxN "same"-padded window generator with stride and valid/ready on both sides.
// One shift stream per channel lane; a single FSM sequences fill, stream, flush and re-arm.
module conv_window_buffer_strided_lane #(
  parameter int N          = 3,
  parameter int BitSize    = 8,
  parameter int ImageWidth = 8
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   shift_i,
  input  logic [BitSize-1:0]     sample_i,
  input  logic [N*N-1:0]         mask_i,
  output logic [N*N*BitSize-1:0] win_o
);
  localparam int L = (N-1)*ImageWidth + N;

  // strm is the stream as it looks after the incoming sample is shifted in
  logic [L-1:0][BitSize-1:0] strm;

  if (L > 1) begin : g_sr
    logic [L-2:0][BitSize-1:0] sr_q;
    always_ff @(posedge clk) begin
      if (res)          sr_q <= '0;
      else if (shift_i) sr_q <= strm[L-2:0];
    end
    assign strm = {sr_q, sample_i};
  end else begin : g_nosr
    assign strm = sample_i;
  end

  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      assign win_o[(i*N+j)*BitSize +: BitSize] =
        mask_i[i*N+j] ? strm[(N-1-i)*ImageWidth + (N-1-j)] : '0;
    end
  end
endmodule

module conv_window_buffer_strided #(
  parameter int N           = 3,
  parameter int BitSize     = 8,
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 8,
  parameter int NumChannels = 1,
  parameter int Stride      = 1
) (
  input  logic                        clk,
  input  logic                        res,
  conv_window_buffer_strided_if.slave bus
);
  localparam int P     = (N-1)/2;
  localparam int CW    = (ImageWidth  > 1) ? $clog2(ImageWidth)  : 1;
  localparam int RW    = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
  localparam int SW    = (Stride      > 1) ? $clog2(Stride)      : 1;
  localparam int LastR = ((ImageHeight-1)/Stride)*Stride;
  localparam int LastC = ((ImageWidth-1)/Stride)*Stride;
  localparam int WinW  = N*N*BitSize;

  typedef enum logic [1:0] {FILL, STREAM, FLUSH, DONE} state_e;

  state_e                           state_q;
  logic [RW-1:0]                    in_r_q, ctr_r_q;
  logic [CW-1:0]                    in_c_q, ctr_c_q;
  logic [SW-1:0]                    ph_r_q, ph_c_q;
  logic                             out_valid_q, out_last_q, out_done_q, last_seen_q;
  logic [NumChannels-1:0][WinW-1:0] out_data_q, win_d;
  logic [N*N-1:0]                   mask_d;
  logic [NumChannels*BitSize-1:0]   sample_d;
  logic adv, in_rdy, acc, shift, flush_step, step, past_fill, emit;
  logic in_end, ctr_end, ctr_last, last_acc;

  assign adv        = !out_valid_q || bus.out_ready;
  assign in_rdy     = !res && (state_q == FILL || state_q == STREAM) && adv;
  assign acc        = bus.in_valid && in_rdy;
  assign flush_step = (state_q == FLUSH) && adv;
  assign shift      = acc || flush_step;
  // once the stream is P rows + P columns deep every new sample completes a centre
  assign past_fill  = (int'(in_r_q) > P) || (int'(in_r_q) == P && int'(in_c_q) >= P);
  assign step       = (acc && past_fill) || flush_step;
  assign emit       = step && (ph_r_q == '0) && (ph_c_q == '0);
  assign in_end     = (in_r_q == RW'(ImageHeight-1)) && (in_c_q == CW'(ImageWidth-1));
  assign ctr_end    = (ctr_r_q == RW'(ImageHeight-1)) && (ctr_c_q == CW'(ImageWidth-1));
  assign ctr_last   = (int'(ctr_r_q) == LastR) && (int'(ctr_c_q) == LastC);
  assign last_acc   = out_valid_q && out_last_q && bus.out_ready;
  assign sample_d   = (state_q == FLUSH) ? '0 : bus.in_data;

  // Padding mask for the current centre; also hides samples wrapped in from a neighbouring row.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mask_d[i*N+j] = (int'(ctr_r_q) + i >= P) && (int'(ctr_r_q) + i < ImageHeight + P) &&
                        (int'(ctr_c_q) + j >= P) && (int'(ctr_c_q) + j < ImageWidth + P);
      end
    end
  end

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_lane
    conv_window_buffer_strided_lane #(
      .N(N), .BitSize(BitSize), .ImageWidth(ImageWidth)
    ) u_lane (
      .clk      (clk),
      .res      (res),
      .shift_i  (shift),
      .sample_i (sample_d[ch*BitSize +: BitSize]),
      .mask_i   (mask_d),
      .win_o    (win_d[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= FILL;
      in_r_q      <= '0;
      in_c_q      <= '0;
      ctr_r_q     <= '0;
      ctr_c_q     <= '0;
      ph_r_q      <= '0;
      ph_c_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_done_q  <= 1'b0;
      last_seen_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_done_q <= 1'b0;
      if (adv) begin
        out_valid_q <= emit;
        out_last_q  <= emit && ctr_last;
        if (emit) out_data_q <= win_d;
      end
      // with stride the last emitted window can be accepted before DONE is reached
      if (last_acc) last_seen_q <= 1'b1;
      if (acc) begin
        if (in_c_q == CW'(ImageWidth-1)) begin
          in_c_q <= '0;
          in_r_q <= (in_r_q == RW'(ImageHeight-1)) ? '0 : in_r_q + 1'b1;
        end else begin
          in_c_q <= in_c_q + 1'b1;
        end
      end
      if (step) begin
        if (ctr_c_q == CW'(ImageWidth-1)) begin
          ctr_c_q <= '0;
          ph_c_q  <= '0;
          if (ctr_r_q == RW'(ImageHeight-1)) begin
            ctr_r_q <= '0;
            ph_r_q  <= '0;
          end else begin
            ctr_r_q <= ctr_r_q + 1'b1;
            ph_r_q  <= (ph_r_q == SW'(Stride-1)) ? '0 : ph_r_q + 1'b1;
          end
        end else begin
          ctr_c_q <= ctr_c_q + 1'b1;
          ph_c_q  <= (ph_c_q == SW'(Stride-1)) ? '0 : ph_c_q + 1'b1;
        end
      end
      unique case (state_q)
        FILL:   if (P == 0 || (acc && int'(in_r_q) == P && int'(in_c_q) == P-1)) state_q <= STREAM;
        STREAM: ;
        FLUSH:  if (flush_step && ctr_end) state_q <= DONE;
        DONE: begin
          if (last_seen_q || last_acc) begin
            out_done_q  <= 1'b1;
            last_seen_q <= 1'b0;
            state_q     <= FILL;
            in_r_q      <= '0;
            in_c_q      <= '0;
            ctr_r_q     <= '0;
            ctr_c_q     <= '0;
            ph_r_q      <= '0;
            ph_c_q      <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
      if (acc && in_end) state_q <= (P == 0) ? DONE : FLUSH;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_done  = out_done_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_conv_window_buffer_strided.sv
// Directed bench: three 4x4 instances (stride 1, stride 2, two channels) with queue monitors.
module tb_conv_window_buffer_strided;
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  conv_window_buffer_strided_if #(.N(3), .BitSize(8), .NumChannels(1)) if1 ();
  conv_window_buffer_strided_if #(.N(3), .BitSize(8), .NumChannels(1)) if2 ();
  conv_window_buffer_strided_if #(.N(3), .BitSize(8), .NumChannels(2)) if3 ();

  conv_window_buffer_strided #(.N(3), .BitSize(8), .ImageWidth(4), .ImageHeight(4),
    .NumChannels(1), .Stride(1)) u_s1 (.clk(clk), .res(res), .bus(if1));
  conv_window_buffer_strided #(.N(3), .BitSize(8), .ImageWidth(4), .ImageHeight(4),
    .NumChannels(1), .Stride(2)) u_s2 (.clk(clk), .res(res), .bus(if2));
  conv_window_buffer_strided #(.N(3), .BitSize(8), .ImageWidth(4), .ImageHeight(4),
    .NumChannels(2), .Stride(1)) u_c2 (.clk(clk), .res(res), .bus(if3));

  logic [71:0]  q1_d[$];
  bit           q1_l[$];
  logic [71:0]  q2_d[$];
  bit           q2_l[$];
  logic [143:0] q3_d[$];
  int done1 = 0, done2 = 0, done3 = 0, acc1 = 0, viol1 = 0;

  // element (i,j) of a 3x3 window, listed in reading order, e0 in the low byte
  function automatic logic [71:0] w9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // expected window centred at (r,c) of the 4x4 image pix = base + r*4 + c + 1, zero outside
  function automatic logic [71:0] ew(input int r, input int c, input int base);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr, cc;
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) w[(i*3+j)*8 +: 8] = 8'(base + rr*4 + cc + 1);
      end
    end
    return w;
  endfunction

  initial forever begin
    @(negedge clk);
    if (res) begin
      q1_d.delete(); q1_l.delete(); done1 = 0; acc1 = 0; viol1 = 0;
    end else begin
      if (if1.out_done) done1++;
      if (acc1 > 0 && acc1 % 16 == 0 && done1 < acc1 / 16 && if1.in_ready) viol1++;
      if (if1.in_valid && if1.in_ready) acc1++;
      if (if1.out_valid && if1.out_ready) begin q1_d.push_back(if1.out_data); q1_l.push_back(if1.out_last); end
    end
  end

  initial forever begin
    @(negedge clk);
    if (res) begin
      q2_d.delete(); q2_l.delete(); done2 = 0;
    end else begin
      if (if2.out_done) done2++;
      if (if2.out_valid && if2.out_ready) begin q2_d.push_back(if2.out_data); q2_l.push_back(if2.out_last); end
    end
  end

  initial forever begin
    @(negedge clk);
    if (res) begin
      q3_d.delete(); done3 = 0;
    end else begin
      if (if3.out_done) done3++;
      if (if3.out_valid && if3.out_ready) q3_d.push_back(if3.out_data);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    if1.in_valid = 0; if2.in_valid = 0; if3.in_valid = 0;
    if1.out_ready = 1; if2.out_ready = 1; if3.out_ready = 1;
    cyc(); cyc();
    res = 1'b0;
  endtask

  // k-th pixel of the stream is (k%16)+1; channel 1 of the dual-channel instance adds 100
  task automatic feed(input int sel, input int npix, input bit gaps);
    for (int k = 0; k < npix; k++) begin
      int pv;
      bit ok;
      pv = k % 16 + 1;
      if (gaps) begin
        if1.in_valid = 0;
        repeat ($urandom_range(0, 2)) cyc();
      end
      case (sel)
        0: begin if1.in_valid = 1; if1.in_data = 8'(pv); end
        1: begin if2.in_valid = 1; if2.in_data = 8'(pv); end
        default: begin if3.in_valid = 1; if3.in_data = {8'(pv + 100), 8'(pv)}; end
      endcase
      ok = 0;
      for (int t = 0; t < 300 && !ok; t++) begin
        @(negedge clk);
        case (sel)
          0: ok = if1.in_ready;
          1: ok = if2.in_ready;
          default: ok = if3.in_ready;
        endcase
        cyc();
      end
      if (!ok) begin
        n_chk++;
        $display("FAIL feed_timeout sel=%0d pixel=%0d never accepted", sel, k);
        break;
      end
    end
    if1.in_valid = 0; if2.in_valid = 0; if3.in_valid = 0;
  endtask

  task automatic wait_done(input int sel, input int n, input int budget);
    int t, d;
    d = 0;
    for (t = 0; t < budget; t++) begin
      d = (sel == 0) ? done1 : (sel == 1) ? done2 : done3;
      if (d >= n) break;
      cyc();
    end
    if (t == budget) begin
      n_chk++;
      $display("FAIL done_timeout sel=%0d got %0d pulses want %0d", sel, d, n);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    res = 1'b1;
    if1.in_valid = 0; if2.in_valid = 0; if3.in_valid = 0;
    if1.in_data = '0; if2.in_data = '0; if3.in_data = '0;
    if1.out_ready = 1; if2.out_ready = 1; if3.out_ready = 1;
    cyc(); cyc();
    n_chk++; if (if1.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", if1.out_valid); else n_pass++;
    n_chk++; if (if1.out_last !== 1'b0) $display("FAIL rst_out_last got %b want 0", if1.out_last); else n_pass++;
    n_chk++; if (if1.out_done !== 1'b0) $display("FAIL rst_out_done got %b want 0", if1.out_done); else n_pass++;
    n_chk++; if (if1.out_data !== 72'd0) $display("FAIL rst_out_data got %h want 0", if1.out_data); else n_pass++;
    n_chk++; if (if1.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", if1.in_ready); else n_pass++;
    n_chk++; if (if3.out_data !== 144'd0) $display("FAIL rst_out_data_c2 got %h want 0", if3.out_data); else n_pass++;
    res = 1'b0;
    cyc();
    n_chk++; if (if1.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", if1.in_ready); else n_pass++;
  endtask

  task automatic check_img1(input string tag, input int nimg);
    n_chk++;
    if (q1_d.size() !== 16*nimg) $display("FAIL %s_count got %0d want %0d", tag, q1_d.size(), 16*nimg); else n_pass++;
    for (int k = 0; k < q1_d.size() && k < 16*nimg; k++) begin
      n_chk++;
      if (q1_d[k] !== ew((k%16)/4, k%4, 0))
        $display("FAIL %s_win%0d got %h want %h", tag, k, q1_d[k], ew((k%16)/4, k%4, 0));
      else n_pass++;
      n_chk++;
      if (q1_l[k] !== (k%16 == 15)) $display("FAIL %s_last%0d got %b want %b", tag, k, q1_l[k], k%16 == 15); else n_pass++;
    end
    n_chk++; if (done1 !== nimg) $display("FAIL %s_done got %0d want %0d", tag, done1, nimg); else n_pass++;
    n_chk++; if (viol1 !== 0) $display("FAIL %s_in_ready_flush got %0d cycles want 0", tag, viol1); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    feed(0, 16, 0);
    wait_done(0, 1, 500);
    if (q1_d.size() >= 16) begin
      n_chk++;
      if (q1_d[0] !== w9(0,0,0, 0,1,2, 0,5,6)) $display("FAIL basic_first got %h want %h", q1_d[0], w9(0,0,0, 0,1,2, 0,5,6));
      else n_pass++;
      n_chk++;
      if (q1_d[15] !== w9(11,12,0, 15,16,0, 0,0,0)) $display("FAIL basic_final got %h want %h", q1_d[15], w9(11,12,0, 15,16,0, 0,0,0));
      else n_pass++;
    end
    check_img1("basic", 1);
  endtask

  task automatic test_stride();
    do_reset();
    feed(1, 16, 0);
    wait_done(1, 1, 500);
    n_chk++; if (q2_d.size() !== 4) $display("FAIL stride_count got %0d want 4", q2_d.size()); else n_pass++;
    for (int k = 0; k < q2_d.size() && k < 4; k++) begin
      n_chk++;
      if (q2_d[k] !== ew((k/2)*2, (k%2)*2, 0)) $display("FAIL stride_win%0d got %h want %h", k, q2_d[k], ew((k/2)*2, (k%2)*2, 0));
      else n_pass++;
      n_chk++; if (q2_l[k] !== (k == 3)) $display("FAIL stride_last%0d got %b want %b", k, q2_l[k], k == 3); else n_pass++;
    end
    if (q2_d.size() >= 2) begin
      n_chk++;
      if (q2_d[1] !== w9(0,0,0, 2,3,4, 6,7,8)) $display("FAIL stride_win2 got %h want %h", q2_d[1], w9(0,0,0, 2,3,4, 6,7,8));
      else n_pass++;
    end
    n_chk++; if (done2 !== 1) $display("FAIL stride_done got %0d want 1", done2); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    fork
      feed(0, 16, 0);
      begin : stall_br
        int t;
        logic [71:0] hold;
        for (t = 0; t < 200; t++) begin
          if (q1_d.size() == 2 && if1.out_valid) break;
          cyc();
        end
        if (t == 200) begin
          n_chk++;
          $display("FAIL stall_wait_timeout third window never presented");
        end else begin
          if1.out_ready = 0;
          hold = if1.out_data;
          n_chk++; if (hold !== ew(0, 2, 0)) $display("FAIL stall_win3 got %h want %h", hold, ew(0, 2, 0)); else n_pass++;
          repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (if1.out_data !== hold || if1.out_valid !== 1'b1)
              $display("FAIL stall_hold got %h/%b want %h/1", if1.out_data, if1.out_valid, hold);
            else n_pass++;
            n_chk++; if (if1.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", if1.in_ready); else n_pass++;
            cyc();
          end
          if1.out_ready = 1;
        end
      end
    join
    wait_done(0, 1, 500);
    check_img1("stall", 1);
  endtask

  task automatic test_channels();
    do_reset();
    feed(2, 16, 0);
    wait_done(2, 1, 500);
    n_chk++; if (q3_d.size() !== 16) $display("FAIL chan_count got %0d want 16", q3_d.size()); else n_pass++;
    for (int k = 0; k < q3_d.size() && k < 16; k++) begin
      n_chk++;
      if (q3_d[k] !== {ew(k/4, k%4, 100), ew(k/4, k%4, 0)})
        $display("FAIL chan_win%0d got %h want %h", k, q3_d[k], {ew(k/4, k%4, 100), ew(k/4, k%4, 0)});
      else n_pass++;
    end
    n_chk++; if (done3 !== 1) $display("FAIL chan_done got %0d want 1", done3); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(0, 7, 0);
    res = 1'b1;
    cyc(); cyc();
    res = 1'b0;
    feed(0, 16, 0);
    wait_done(0, 1, 500);
    check_img1("rstmid", 1);
  endtask

  task automatic test_back_to_back();
    bit stop;
    stop = 0;
    do_reset();
    fork
      begin
        feed(0, 32, 1);
        wait_done(0, 2, 3000);
        stop = 1;
      end
      begin
        while (!stop) begin
          cyc();
          if (!stop) if1.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    if1.out_ready = 1;
    check_img1("b2b", 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_stall();
    test_channels();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
